apbs_regfile: RTL and testbench
===============================

# apbs_regfile

APB4 completer (slave) that terminates transfers issued by the APB master on the same bus and backs them with a byte-strobed register file. It decodes PADDR to a word index and inserts a fixed, parameterised number of wait states via PREADY. It flags out-of-range or misaligned accesses with PSLVERR. It is the responder end of the bus, used as the bus-side model in the master's environment and as a generic peripheral register block.

## Interface
- DEPTH, 16: number of 32-bit registers, 1..64; occupies byte addresses 0 .. 4*DEPTH-1
- WAIT_STATES, 1: access-phase cycles with PREADY low before completion, 0..7
- PCLK  input  1  bus clock; all state changes on rising edge
- PRESET  input  1  asynchronous, active-high reset
- PADDR  input  8  byte address
- PSEL  input  1  completer select
- PENABLE  input  1  access-phase indicator
- PWRITE  input  1  1 = write, 0 = read
- PWDATA  input  32  write data
- PSTRB  input  4  write byte-lane strobes; PSTRB[i] enables PWDATA[8i+7:8i]
- PRDATA  output  32  read data
- PREADY  output  1  transfer-complete indicator
- PSLVERR  output  1  transfer-error indicator

## Operation
- States: IDLE, ACCESS.
- IDLE -> ACCESS: PSEL=1 and PENABLE=0 sampled (setup phase).
  - Latch PADDR, PWRITE, PWDATA, PSTRB.
  - Load wait counter with WAIT_STATES.
  - Compute the error flag.
- Error condition: PADDR[1:0] != 0, or PADDR[7:2] >= DEPTH.
- ACCESS: each cycle with PREADY=0 decrements the counter. PREADY goes high when the counter reaches 0.
- Completion: PSEL=1, PENABLE=1 and PREADY=1 sampled on the same edge.
  - Write, no error: for each lane i with PSTRB[i]=1, update byte i of reg[PADDR[7:2]]. PSTRB=0 is a legal no-op.
  - Write, error: no register changes.
  - Read: PSTRB is ignored.
  - Next state: IDLE. If PSEL=1 and PENABLE=0 on the following cycle, a new setup is taken from IDLE as normal (back-to-back).
- Abort: PSEL=0 sampled while in ACCESS.
  - Return to IDLE; no write; PREADY and PSLVERR cleared.
- PENABLE=1 while in IDLE (setup missing) is ignored; the block stays in IDLE.
- Address, data and strobe changes during ACCESS are ignored; the values latched at setup are used.

## Timing
- Reset (async assert, sync release):
  - All registers = 0x0000_0000.
  - PRDATA = 0, PREADY = 0, PSLVERR = 0.
  - State = IDLE.
  - An in-flight transfer is dropped with no write.
- PREADY is registered.
  - It is high in the (WAIT_STATES+1)-th access cycle and low in every other cycle.
  - A transfer therefore spans 2 + WAIT_STATES cycles including setup. WAIT_STATES=0 gives the minimal 2-cycle APB transfer.
- PSLVERR is high only in the cycle where PREADY=1 and the error flag is set; it is 0 otherwise.
- PRDATA, on a read:
  - Equals reg[PADDR[7:2]] in the cycle PREADY=1.
  - Is 0 on an errored read.
  - Is 0 whenever PREADY=0 or the transfer is a write.
- Write data is visible to a read whose setup begins on the cycle after completion; there is no forwarding hazard.
- Read data reflects register contents at completion.

## Test plan
- Reset then read addresses 0x00 and 0x3C, WAIT_STATES=1: PREADY high in the 2nd access cycle; PRDATA=0x0000_0000, PSLVERR=0.
- Write 0xDEADBEEF to 0x08 with PSTRB=4'hF, then write 0x11223344 to 0x08 with PSTRB=4'b0101, then read 0x08: PRDATA=0xDE22BE44.
- Access 0x40 with DEPTH=16, and 0x05 (misaligned): PSLVERR=1 with PREADY; a write leaves all registers unchanged; a read returns PRDATA=0.
- WAIT_STATES=0 and WAIT_STATES=7, back-to-back write then read to 0x10: PREADY high in access cycle 1 and cycle 8 respectively; the read returns the written value; no idle cycle is required between transfers.
- Drop PSEL in access cycle 1 of a write with WAIT_STATES=3: no register update, PREADY never rises, state returns to IDLE; a following normal read to the same address returns the old value.
- Assert PRESET mid-access after a prior write to 0x00: PREADY and PSLVERR drop immediately; a read of 0x00 after release returns 0.

Source files
------------

// File: rtl/apbs_regfile.sv
// apbs_regfile: APB4 completer backed by a byte-strobed 32-bit register file.
// The completer inserts a fixed number of wait states and flags misaligned or
// out-of-range accesses with PSLVERR. PRDATA, PREADY and PSLVERR are registered.
module apbs_regfile #(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [7:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_r;
    logic [5:0]  idx_r;
    logic        wr_r;
    logic        err_r;
    logic [31:0] wdata_r;
    logic [3:0]  strb_r;
    logic [2:0]  cnt_r;
    logic [31:0] regs_r [DEPTH];

    logic        setup_s;
    logic        complete_s;
    logic        setup_err_s;
    logic [5:0]  rd_idx_s;
    logic        rd_err_s;
    logic        rd_wr_s;
    logic [31:0] rd_word_s;
    logic [31:0] rsp_data_s;
    logic        do_write_s;

    // Misaligned byte address or word index beyond the implemented registers.
    function automatic logic addr_err(input logic [7:0] addr);
        return (addr[1:0] != 2'b00) || ({1'b0, addr[7:2]} >= 7'(DEPTH));
    endfunction

    // Phase decode and write qualification from the latched transfer.
    always_comb begin
        setup_s     = PSEL & ~PENABLE;
        complete_s  = PSEL & PENABLE & PREADY;
        setup_err_s = addr_err(PADDR);
        do_write_s  = (state_r == ACCESS) & complete_s & wr_r & ~err_r;
    end

    // Response source: live bus when PREADY is raised at setup (no wait states),
    // latched values otherwise.
    always_comb begin
        if (state_r == IDLE) begin
            rd_idx_s = PADDR[7:2];
            rd_err_s = setup_err_s;
            rd_wr_s  = PWRITE;
        end else begin
            rd_idx_s = idx_r;
            rd_err_s = err_r;
            rd_wr_s  = wr_r;
        end
    end

    // Read mux over the register file; errored reads and writes return zero.
    always_comb begin
        rd_word_s = 32'h0000_0000;
        for (int i = 0; i < DEPTH; i++) begin
            rd_word_s = (rd_idx_s == 6'(i)) ? regs_r[i] : rd_word_s;
        end
        if (rd_err_s || rd_wr_s) begin
            rsp_data_s = 32'h0000_0000;
        end else begin
            rsp_data_s = rd_word_s;
        end
    end

    // Transfer FSM with registered PREADY/PSLVERR/PRDATA and wait-state counter.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= IDLE;
            idx_r   <= 6'd0;
            wr_r    <= 1'b0;
            err_r   <= 1'b0;
            wdata_r <= 32'h0000_0000;
            strb_r  <= 4'h0;
            cnt_r   <= 3'd0;
            PRDATA  <= 32'h0000_0000;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (setup_s) begin
                        state_r <= ACCESS;
                        idx_r   <= PADDR[7:2];
                        wr_r    <= PWRITE;
                        err_r   <= setup_err_s;
                        wdata_r <= PWDATA;
                        strb_r  <= PSTRB;
                        cnt_r   <= 3'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= setup_err_s;
                            PRDATA  <= rsp_data_s;
                        end else begin
                            PREADY  <= 1'b0;
                            PSLVERR <= 1'b0;
                            PRDATA  <= 32'h0000_0000;
                        end
                    end else begin
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= 32'h0000_0000;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        // Master abandoned the transfer.
                        state_r <= IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= 32'h0000_0000;
                    end else if (PREADY) begin
                        if (PENABLE) begin
                            state_r <= IDLE;
                            PREADY  <= 1'b0;
                            PSLVERR <= 1'b0;
                            PRDATA  <= 32'h0000_0000;
                        end else begin
                            state_r <= ACCESS;
                        end
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                        if (cnt_r == 3'd1) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= err_r;
                            PRDATA  <= rsp_data_s;
                        end else begin
                            PREADY  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Register file: byte-lane writes on error-free write completion.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (do_write_s && (idx_r == 6'(i)) && strb_r[b]) begin
                        regs_r[i][8*b +: 8] <= wdata_r[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apbs_regfile.sv
// Directed bench for apbs_regfile: four instances with different wait-state
// counts share the bus lines, each with its own PSEL.
module tb_apbs_regfile;

    logic        PCLK;
    logic        PRESET;
    logic [7:0]  paddr;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [3:0]  psel_v;
    logic [31:0] prdata_a  [4];
    logic        pready_a  [4];
    logic        pslverr_a [4];

    int tests = 0;
    int fails = 0;

    apbs_regfile #(.DEPTH(16), .WAIT_STATES(1)) u_ws1 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PSEL(psel_v[0]),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata_a[0]), .PREADY(pready_a[0]), .PSLVERR(pslverr_a[0]));
    apbs_regfile #(.DEPTH(16), .WAIT_STATES(0)) u_ws0 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PSEL(psel_v[1]),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata_a[1]), .PREADY(pready_a[1]), .PSLVERR(pslverr_a[1]));
    apbs_regfile #(.DEPTH(16), .WAIT_STATES(7)) u_ws7 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PSEL(psel_v[2]),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata_a[2]), .PREADY(pready_a[2]), .PSLVERR(pslverr_a[2]));
    apbs_regfile #(.DEPTH(16), .WAIT_STATES(3)) u_ws3 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PSEL(psel_v[3]),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata_a[3]), .PREADY(pready_a[3]), .PSLVERR(pslverr_a[3]));

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int          k;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int k, logic wr, logic [7:0] addr, logic [31:0] wd,
                                logic [3:0] st, logic [31:0] exp_rd, logic exp_err,
                                int exp_cyc);
        vec_t v;
        v.k = k; v.wr = wr; v.addr = addr; v.wd = wd; v.st = st;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the completion edge so a
    // following call starts its setup back-to-back.
    task automatic xfer(input int k, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int cyc,
                        output logic quiet_ok);
        psel_v    = 4'b0000;
        psel_v[k] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = wd;
        pstrb     = st;
        rd        = 32'h0;
        er        = 1'b0;
        cyc       = 0;
        quiet_ok  = 1'b1;
        @(posedge PCLK); #1;
        penable = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge PCLK);
            if (pready_a[k] === 1'b1) begin
                rd  = prdata_a[k];
                er  = pslverr_a[k];
                cyc = n;
                break;
            end
            if (pslverr_a[k] !== 1'b0 || prdata_a[k] !== 32'h0) quiet_ok = 1'b0;
            @(posedge PCLK); #1;
        end
        @(posedge PCLK); #1;
        psel_v  = 4'b0000;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        logic        quiet;
        logic        rose;

        PRESET  = 1'b1;
        psel_v  = 4'b0000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 32'h0;
        pstrb   = 4'h0;

        // WAIT_STATES=1 instance: reset reads, strobed writes, errors, no-op strobe.
        vecs.push_back(mk(0, 1'b0, 8'h00, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 8'h3C, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(0, 1'b1, 8'h08, 32'hDEADBEEF,  4'hF, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(0, 1'b1, 8'h08, 32'h11223344,  4'h5, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 8'h08, 32'h0,         4'h0, 32'hDE22BE44, 1'b0, 2));
        vecs.push_back(mk(0, 1'b1, 8'h40, 32'hFFFFFFFF,  4'hF, 32'h0000_0000, 1'b1, 2));
        vecs.push_back(mk(0, 1'b1, 8'h05, 32'hFFFFFFFF,  4'hF, 32'h0000_0000, 1'b1, 2));
        vecs.push_back(mk(0, 1'b0, 8'h40, 32'h0,         4'h0, 32'h0000_0000, 1'b1, 2));
        vecs.push_back(mk(0, 1'b0, 8'h05, 32'h0,         4'h0, 32'h0000_0000, 1'b1, 2));
        vecs.push_back(mk(0, 1'b0, 8'h08, 32'h0,         4'hF, 32'hDE22BE44, 1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 8'h04, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 8'h3C, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(0, 1'b1, 8'h0C, 32'h12345678,  4'h0, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 8'h0C, 32'h0,         4'hF, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(0, 1'b1, 8'h00, 32'h5A5A5A5A,  4'hF, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(0, 1'b0, 8'h00, 32'h0,         4'h0, 32'h5A5A5A5A, 1'b0, 2));
        // WAIT_STATES=0, 7 and 3: back-to-back write then read of 0x10.
        vecs.push_back(mk(1, 1'b1, 8'h10, 32'hCAFEF00D,  4'hF, 32'h0000_0000, 1'b0, 1));
        vecs.push_back(mk(1, 1'b0, 8'h10, 32'h0,         4'h0, 32'hCAFEF00D, 1'b0, 1));
        vecs.push_back(mk(2, 1'b1, 8'h10, 32'hA5A55A5A,  4'hF, 32'h0000_0000, 1'b0, 8));
        vecs.push_back(mk(2, 1'b0, 8'h10, 32'h0,         4'h0, 32'hA5A55A5A, 1'b0, 8));
        vecs.push_back(mk(3, 1'b1, 8'h10, 32'h01020304,  4'hF, 32'h0000_0000, 1'b0, 4));
        vecs.push_back(mk(3, 1'b0, 8'h10, 32'h0,         4'h0, 32'h01020304, 1'b0, 4));

        repeat (3) @(posedge PCLK);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_prdata_%0d", k), prdata_a[k], 32'h0);
            check($sformatf("reset_pready_%0d", k), {31'h0, pready_a[k]}, 32'h0);
            check($sformatf("reset_pslverr_%0d", k), {31'h0, pslverr_a[k]}, 32'h0);
        end
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].st,
                 rd, er, cyc, quiet);
            check($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rd);
            check($sformatf("v%0d_pslverr", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            check($sformatf("v%0d_ready_cycle", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_quiet_wait", i), {31'h0, quiet}, 32'h1);
        end

        // Abort: PSEL dropped in access cycle 1 of a write (WAIT_STATES=3).
        @(posedge PCLK); #1;
        psel_v  = 4'b1000;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h10;
        pwdata  = 32'hFFFF_FFFF;
        pstrb   = 4'hF;
        @(posedge PCLK); #1;
        psel_v  = 4'b0000;
        rose    = 1'b0;
        repeat (10) begin
            @(negedge PCLK);
            if (pready_a[3] !== 1'b0) rose = 1'b1;
        end
        check("abort_pready_rose", {31'h0, rose}, 32'h0);
        @(posedge PCLK); #1;
        xfer(3, 1'b0, 8'h10, 32'h0, 4'h0, rd, er, cyc, quiet);
        check("abort_old_value", rd, 32'h01020304);
        check("abort_next_cycle", 32'(cyc), 32'd4);

        // Reset mid-access during an errored read with PREADY/PSLVERR high.
        @(posedge PCLK); #1;
        psel_v  = 4'b0001;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h40;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        check("pre_reset_pready", {31'h0, pready_a[0]}, 32'h1);
        check("pre_reset_pslverr", {31'h0, pslverr_a[0]}, 32'h1);
        #2;
        PRESET = 1'b1;
        #1;
        check("midreset_pready", {31'h0, pready_a[0]}, 32'h0);
        check("midreset_pslverr", {31'h0, pslverr_a[0]}, 32'h0);
        check("midreset_prdata", prdata_a[0], 32'h0);
        @(posedge PCLK); #1;
        psel_v  = 4'b0000;
        penable = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, rd, er, cyc, quiet);
        check("post_reset_reg0", rd, 32'h0);
        check("post_reset_cycle", 32'(cyc), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
